// File: rtl/memory.sv
// Memory pipeline stage: registers execute results and runs the data-memory req/ack handshake.
// Optional: define MEM_MISALIGN_EN to flag and suppress misaligned half/word accesses.
module memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_write_e,
    input  logic [1:0]  rd_write_src_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] alu_res_e,
    input  logic        mem_read_e,
    input  logic        mem_write_e,
    input  logic [1:0]  mem_size_e,
    input  logic        mem_unsigned_e,
    input  logic [31:0] mem_write_data_e,
    output logic        stall_m,
    output logic        rd_write_m,
    output logic [1:0]  rd_write_src_m,
    output logic [4:0]  rd_m,
    output logic [31:0] pc_m,
    output logic [31:0] alu_res_m,
    output logic [31:0] mem_read_data_m,
    output logic        misalign_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e      state_r, state_d;
    logic        rd_write_r;
    logic [1:0]  rd_write_src_r;
    logic [4:0]  rd_r;
    logic [31:0] pc_r;
    logic [31:0] alu_res_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [1:0]  mem_size_r;
    logic        mem_unsigned_r;
    logic [31:0] mem_write_data_r;

    logic        misalign_e;
    logic        in_access;
    logic [1:0]  a;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

`ifdef MEM_MISALIGN_EN
    logic misalign_r;

    assign misalign_e = (mem_read_e | mem_write_e) &
                        (((mem_size_e == 2'b01) & alu_res_e[0]) |
                         (mem_size_e[1] & (alu_res_e[1:0] != 2'b00)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else if (!stall_m) begin
            misalign_r <= misalign_e;
        end
    end

    assign misalign_m = misalign_r;
`else
    assign misalign_e = 1'b0;
    assign misalign_m = 1'b0;
`endif

    assign in_access = (state_r == StAccess);
    assign stall_m   = in_access & ~dmem_ack;

    // Whenever the register advances, the incoming instruction decides the next state.
    always_comb begin
        state_d = state_r;
        if (!stall_m) begin
            state_d = ((mem_read_e | mem_write_e) & ~misalign_e) ? StAccess : StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= StIdle;
            rd_write_r       <= 1'b0;
            rd_write_src_r   <= 2'b00;
            rd_r             <= 5'd0;
            pc_r             <= 32'd0;
            alu_res_r        <= 32'd0;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_size_r       <= 2'b00;
            mem_unsigned_r   <= 1'b0;
            mem_write_data_r <= 32'd0;
        end else begin
            state_r <= state_d;
            if (!stall_m) begin
                rd_write_r       <= rd_write_e;
                rd_write_src_r   <= rd_write_src_e;
                rd_r             <= rd_e;
                pc_r             <= pc_e;
                alu_res_r        <= alu_res_e;
                mem_read_r       <= mem_read_e;
                mem_write_r      <= mem_write_e;
                mem_size_r       <= mem_size_e;
                mem_unsigned_r   <= mem_unsigned_e;
                mem_write_data_r <= mem_write_data_e;
            end
        end
    end

    assign a = alu_res_r[1:0];

    always_comb begin
        be_raw    = 4'hF;
        wdata_raw = mem_write_data_r;
        case (mem_size_r)
            2'b00: begin
                be_raw    = 4'b0001 << a;
                wdata_raw = {4{mem_write_data_r[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << {a[1], 1'b0};
                wdata_raw = {2{mem_write_data_r[15:0]}};
            end
            default: begin
                be_raw    = 4'hF;
                wdata_raw = mem_write_data_r;
            end
        endcase
    end

    assign byte_sel = dmem_rdata[{a, 3'b000} +: 8];
    assign half_sel = dmem_rdata[{a[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem_rdata;
        case (mem_size_r)
            2'b00:   load_ext = {{24{~mem_unsigned_r & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~mem_unsigned_r & half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Request fields are forced to 0 outside an access so idle and reset look identical.
    assign dmem_req   = in_access;
    assign dmem_we    = in_access & mem_write_r;
    assign dmem_addr  = in_access ? {alu_res_r[31:2], 2'b00} : 32'd0;
    assign dmem_be    = in_access ? be_raw : 4'b0000;
    assign dmem_wdata = in_access ? wdata_raw : 32'd0;

    assign mem_read_data_m = (in_access & dmem_ack & mem_read_r) ? load_ext : 32'd0;

    assign rd_write_m     = rd_write_r & ~stall_m & ~misalign_m;
    assign rd_write_src_m = rd_write_src_r;
    assign rd_m           = rd_r;
    assign pc_m           = pc_r;
    assign alu_res_m      = alu_res_r;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: random instruction stream and random wait states
// checked each cycle against a transaction-level model, plus directed corner cases.
module tb_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_write_e;
    logic [1:0]  rd_write_src_e;
    logic [4:0]  rd_e;
    logic [31:0] pc_e, alu_res_e;
    logic        mem_read_e, mem_write_e;
    logic [1:0]  mem_size_e;
    logic        mem_unsigned_e;
    logic [31:0] mem_write_data_e;
    logic        stall_m, rd_write_m;
    logic [1:0]  rd_write_src_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_m, alu_res_m, mem_read_data_m;
    logic        misalign_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    memory dut (
        .clk(clk), .rst(rst),
        .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e), .rd_e(rd_e),
        .pc_e(pc_e), .alu_res_e(alu_res_e),
        .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .mem_size_e(mem_size_e),
        .mem_unsigned_e(mem_unsigned_e), .mem_write_data_e(mem_write_data_e),
        .stall_m(stall_m), .rd_write_m(rd_write_m), .rd_write_src_m(rd_write_src_m),
        .rd_m(rd_m), .pc_m(pc_m), .alu_res_m(alu_res_m), .mem_read_data_m(mem_read_data_m),
        .misalign_m(misalign_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd_write;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
    } instr_t;

    int errors = 0;
    int checks = 0;

    // Reference model: instruction currently in the stage and its outstanding access.
    instr_t      cur;
    bit          pending;
    int          wl;
    logic [31:0] cur_rdata;

    logic [31:0] first_be, first_wdata, first_mrd, first_addr, last_mrd;
    logic        first_req, first_we, first_rdw, first_mis;
    int          stalls;
    bit          rdw_in_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_base(input instr_t i);
        int n = nbytes(i.size);
        return (n == 4) ? 0 : (int'(i.alu[1:0]) / n) * n;
    endfunction

    function automatic bit is_acc(input instr_t i);
        return i.mem_read || i.mem_write;
    endfunction

    function automatic bit is_mis(input instr_t i);
`ifdef MEM_MISALIGN_EN
        return is_acc(i) && ((int'(i.alu[1:0]) % nbytes(i.size)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input instr_t i);
        logic [3:0] r = '0;
        int n = nbytes(i.size);
        int b = lane_base(i);
        for (int k = 0; k < n; k++) r[b + k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_wdata(input instr_t i);
        logic [31:0] r = '0;
        int n = nbytes(i.size);
        for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = i.wd[8*(lane % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_val(input instr_t i, input logic [31:0] rdat);
        logic [31:0] v = '0;
        int n = nbytes(i.size);
        int b = lane_base(i);
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdat[8*(b + k) +: 8];
        if (n < 4 && !i.uns && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic instr_t mk_mem(input bit rd_, input bit wr, input logic [1:0] sz,
                                      input bit uns, input logic [31:0] addr,
                                      input logic [31:0] wd);
        instr_t i = '0;
        i.mem_read = rd_; i.mem_write = wr; i.size = sz; i.uns = uns;
        i.alu = addr; i.wd = wd; i.rd_write = rd_; i.rd = 5'd5;
        i.src = rd_ ? 2'b01 : 2'b00; i.pc = 32'h0000_0100 + addr;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int k = $urandom_range(0, 2);
        i.pc = $urandom; i.alu = $urandom; i.wd = $urandom;
        i.rd = 5'($urandom); i.src = 2'($urandom); i.size = 2'($urandom); i.uns = 1'($urandom);
        i.rd_write = 1'($urandom);
        i.mem_read = (k == 1); i.mem_write = (k == 2);
        if (k == 1) i.rd_write = 1'b1;
        if (k == 2) i.rd_write = 1'b0;
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i = '0;
        i.rd_write = 1'b1; i.rd = 5'd7; i.alu = $urandom; i.pc = $urandom;
        return i;
    endfunction

    task automatic drive_e(input instr_t i);
        rd_write_e = i.rd_write; rd_write_src_e = i.src; rd_e = i.rd; pc_e = i.pc;
        alu_res_e = i.alu; mem_read_e = i.mem_read; mem_write_e = i.mem_write;
        mem_size_e = i.size; mem_unsigned_e = i.uns; mem_write_data_e = i.wd;
    endtask

    task automatic check_outputs(input bit exp_stall, input bit ack_now);
        bit mis = is_mis(cur);
        check_eq("stall_m", stall_m, exp_stall);
        check_eq("rd_write_m", rd_write_m, cur.rd_write && !exp_stall && !mis);
        check_eq("rd_write_src_m", rd_write_src_m, cur.src);
        check_eq("rd_m", rd_m, cur.rd);
        check_eq("pc_m", pc_m, cur.pc);
        check_eq("alu_res_m", alu_res_m, cur.alu);
        check_eq("misalign_m", misalign_m, mis);
        check_eq("dmem_req", dmem_req, pending);
        check_eq("dmem_we", dmem_we, pending && cur.mem_write);
        check_eq("dmem_addr", dmem_addr, pending ? {cur.alu[31:2], 2'b00} : 32'd0);
        check_eq("dmem_be", dmem_be, pending ? exp_be(cur) : 4'd0);
        check_eq("dmem_wdata", dmem_wdata, pending ? exp_wdata(cur) : 32'd0);
        check_eq("mem_read_data_m", mem_read_data_m,
                 (ack_now && cur.mem_read) ? load_val(cur, cur_rdata) : 32'd0);
    endtask

    // Runs cycles until nxt is accepted into the stage; memory answers after nwait wait states.
    task automatic issue(input instr_t nxt, input int nwait, input logic [31:0] nrd);
        bit done = 0;
        bit first = 1;
        bit ack_now, exp_stall;
        stalls = 0;
        rdw_in_stall = 0;
        while (!done) begin
            @(negedge clk);
            ack_now = pending && (wl == 0);
            dmem_ack = pending ? ack_now : ($urandom_range(0, 3) == 0);
            dmem_rdata = ack_now ? cur_rdata : $urandom;
            exp_stall = pending && !ack_now;
            if (exp_stall) drive_e(rand_instr());
            else drive_e(nxt);
            #1;
            check_outputs(exp_stall, ack_now);
            if (first) begin
                first_be = {28'd0, dmem_be}; first_wdata = dmem_wdata; first_mrd = mem_read_data_m;
                first_addr = dmem_addr; first_req = dmem_req; first_we = dmem_we;
                first_rdw = rd_write_m; first_mis = misalign_m;
                first = 0;
            end
            last_mrd = mem_read_data_m;
            if (exp_stall && rd_write_m) rdw_in_stall = 1;
            @(posedge clk);
            if (exp_stall) begin
                wl--;
                stalls++;
            end else begin
                cur = nxt;
                pending = is_acc(nxt) && !is_mis(nxt);
                wl = nwait;
                cur_rdata = nrd;
                done = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive_e('0);
        cur = '0; pending = 0; wl = 0; cur_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        check_outputs(1'b0, 1'b0);
        dmem_ack = 1'b0;
        rst = 1'b0;

        // LB from 0x1003, zero-wait, sign-extended top byte.
        issue(mk_mem(1, 0, 2'b00, 0, 32'h0000_1003, 32'd0), 0, 32'h80FF_FF00);
        issue(nop(), 0, 32'd0);
        check_eq("lb_be", first_be, 32'h8);
        check_eq("lb_data", first_mrd, 32'hFFFF_FF80);
        check_eq("lb_stalls", stalls, 0);

        // LHU from 0x2002 with three wait states.
        issue(mk_mem(1, 0, 2'b01, 1, 32'h0000_2002, 32'd0), 3, 32'hBEEF_0000);
        issue(nop(), 0, 32'd0);
        check_eq("lhu_stalls", stalls, 3);
        check_eq("lhu_data", last_mrd, 32'h0000_BEEF);
        check_eq("lhu_rdw_in_stall", rdw_in_stall, 0);

        // SB to 0x3001.
        issue(mk_mem(0, 1, 2'b00, 0, 32'h0000_3001, 32'h1234_56AB), 0, 32'd0);
        issue(nop(), 0, 32'd0);
        check_eq("sb_we", first_we, 1);
        check_eq("sb_be", first_be, 32'h2);
        check_eq("sb_wdata", first_wdata, 32'hABAB_ABAB);
        check_eq("sb_rdw", first_rdw, 0);

        // Back-to-back LW, each acked in its first cycle.
        issue(mk_mem(1, 0, 2'b10, 0, 32'h0000_5000, 32'd0), 0, 32'h1111_2222);
        issue(mk_mem(1, 0, 2'b10, 0, 32'h0000_5004, 32'd0), 0, 32'h3333_4444);
        check_eq("b2b_req1", first_req, 1);
        check_eq("b2b_stall1", stalls, 0);
        issue(nop(), 0, 32'd0);
        check_eq("b2b_req2", first_req, 1);
        check_eq("b2b_stall2", stalls, 0);

        // LW from 0x4002.
        issue(mk_mem(1, 0, 2'b10, 0, 32'h0000_4002, 32'd0), 0, 32'hCAFE_F00D);
        issue(nop(), 0, 32'd0);
`ifdef MEM_MISALIGN_EN
        check_eq("lw_mis_req", first_req, 0);
        check_eq("lw_mis_flag", first_mis, 1);
        check_eq("lw_mis_rdw", first_rdw, 0);
`else
        check_eq("lw_addr", first_addr, 32'h0000_4000);
        check_eq("lw_req", first_req, 1);
        check_eq("lw_data", first_mrd, 32'hCAFE_F00D);
`endif

        for (int n = 0; n < 300; n++) issue(rand_instr(), $urandom_range(0, 3), $urandom);

        // Reset in the middle of an outstanding access.
        issue(mk_mem(1, 0, 2'b10, 0, 32'h0000_6000, 32'd0), 4, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive_e('0);
        #1;
        check_eq("pre_rst_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", stall_m, 0);
        check_eq("rst_rdw", rd_write_m, 0);
        check_eq("rst_pc", pc_m, 32'd0);
        cur = '0; pending = 0; wl = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 50; n++) issue(rand_instr(), $urandom_range(0, 3), $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
